id_interlock: RTL and testbench
===============================

# id_interlock

Register-scoreboard interlock controller for the MINA2000 in-order pipeline. It sits beside the instruction decode stage and tracks how many in-flight instructions will write each architectural register. It stalls decode while a source operand or the destination still has an older write pending, so the register file never supplies stale data. It also owns the single "issue" strobe that advances the ID/EX pipeline register.

## Interface

Parameters:
- CNT_W, 2: width of each per-register pending counter; maximum in-flight writes per register is 2^CNT_W-1.
- WB_BYPASS, 0: when 1, a same-cycle writeback releases a hazard combinationally; when 0, release happens the cycle after writeback.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a decoded instruction.
- id_uses_ra  in  1  instruction reads ra.
- id_uses_rb  in  1  instruction reads rb.
- id_ra_addr  in  5  source A register.
- id_rb_addr  in  5  source B register.
- id_rd_addr  in  5  destination register; 0 means no write.
- ex_ready  in  1  ID/EX register can accept.
- flush  in  1  redirect from EX; the instruction in ID is discarded this cycle.
- cancel_valid  in  1  an already-issued instruction was squashed downstream.
- cancel_rd_addr  in  5  destination of the squashed instruction.
- wb_valid  in  1  writeback this cycle.
- wb_rd_addr  in  5  writeback destination.
- id_stall  out  1  hold IF/ID; combinational.
- issue  out  1  advance ID to EX this cycle; combinational.
- pending  out  32  bit r = counter[r] != 0; registered state, bit 0 always 0.
- busy  out  1  OR of pending.
- sb_err  out  1  sticky: a decrement hit a zero counter.
- stall_cycles  out  32  saturating count of cycles with id_stall=1.

## Operation

- State: counter[1..31], each CNT_W bits. Register 0 is not stored and always reads as 0. sb_err and stall_cycles are also state.
- Hazard terms, each evaluated on the registered counter (see WB_BYPASS):
  - haz_a = id_uses_ra and ra != 0 and counter[ra] != 0.
  - haz_b = id_uses_rb and rb != 0 and counter[rb] != 0.
  - haz_d = rd != 0 and counter[rd] == max (saturation guard, write-after-write overflow).
- id_stall = id_valid and not flush and (haz_a or haz_b or haz_d).
- issue = id_valid and not flush and not id_stall and ex_ready.
  - ex_ready=0 with no hazard gives issue=0 and id_stall=0; back-pressure is the upstream's job.
- WB_BYPASS=1: haz_a/haz_b ignore one pending write when wb_valid and wb_rd_addr matches the source and the counter equals 1.
- Per-register update each edge, r ≠ 0:
  - inc = issue and rd==r.
  - dec = (wb_valid and wb_rd_addr==r) + (cancel_valid and cancel_rd_addr==r), giving 0, 1 or 2.
  - counter[r] ← counter[r] + inc − dec, evaluated at CNT_W+1 bits.
  - A negative result sets the counter to 0 and sets sb_err.
  - inc at max cannot occur because haz_d blocks it.
- Decrements addressed to r=0 are ignored and do not set sb_err.
- sb_err clears only on rst.
- stall_cycles increments when id_stall=1 and holds at 0xFFFF_FFFF.

## Timing

- Reset (rst high, asynchronous): all counters 0, pending=0, busy=0, sb_err=0, stall_cycles=0. id_stall/issue follow their inputs with empty state; they are 0 if id_valid=0.
- Issue latency: after issue in cycle N, pending[rd] is visible from cycle N+1.
- Release latency, WB_BYPASS=0: wb in cycle N clears pending in N+1; a dependent instruction issues in N+1.
- Release latency, WB_BYPASS=1: the dependent instruction issues in cycle N.
- Same-cycle issue and writeback to the same register leave the counter unchanged.
- Simultaneous issue, wb and cancel to the same register give a net −1.
- flush has priority over hazards: id_stall=0 and issue=0. flush does not touch counters; squashed in-flight instructions are reported via cancel.
- rst asserted mid-operation clears state immediately, regardless of in-flight writebacks.

## Test plan

- RAW, WB_BYPASS=0: issue rd=5; next instruction ra=5 with id_valid held → id_stall=1 until the cycle after wb_rd_addr=5, then issue=1. stall_cycles equals the stall length.
- Bypass, WB_BYPASS=1: same sequence → issue=1 in the wb cycle itself.
- Saturation, CNT_W=2: three issues to rd=7 with no wb → the fourth rd=7 instruction stalls (haz_d). One wb to 7 → it issues next cycle; pending[7] stays 1.
- Simultaneous events: counter[3]=1, issue rd=3 with wb 3 in the same cycle → counter stays 1. Adding cancel 3 in that cycle instead → counter 0, pending[3]=0.
- r0 and error: rd=0 issue leaves pending=0. ra=0 never stalls. wb to r9 while counter[9]=0 → sb_err=1 and stays 1 until rst.
- Flush and reset: a hazard in ID plus flush=1 → id_stall=0, issue=0. rst pulse mid-stream with pending=0x0000_0120 → pending=0, busy=0, stall_cycles=0 immediately.

Source files
------------

// File: rtl/id_interlock.sv
// Register-scoreboard interlock for the decode stage. It keeps a pending-write counter
// per architectural register, stalls decode on RAW/WAW-overflow hazards, and owns the ID/EX issue strobe.
module id_interlock #(
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_uses_ra,
    input  logic        id_uses_rb,
    input  logic [4:0]  id_ra_addr,
    input  logic [4:0]  id_rb_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        cancel_valid,
    input  logic [4:0]  cancel_rd_addr,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd_addr,
    output logic        id_stall,
    output logic        issue,
    output logic [31:0] pending,
    output logic        busy,
    output logic        sb_err,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0][CNT_W-1:0] cnt_flat;
    logic [31:0]            underflow;

    logic [CNT_W-1:0] cnt_ra;
    logic [CNT_W-1:0] cnt_rb;
    logic [CNT_W-1:0] cnt_rd;
    logic             byp_a;
    logic             byp_b;
    logic             haz_a;
    logic             haz_b;
    logic             haz_d;
    logic             sb_err_reg;
    logic [31:0]      stall_cycles_reg;

    // Register 0 is never stored: it reads as an empty counter and ignores decrements.
    assign cnt_flat[0]  = '0;
    assign underflow[0] = 1'b0;
    assign pending[0]   = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W:0]   cnt_next;
            logic [CNT_W:0]   sum;
            logic [1:0]       dec;
            logic             inc;
            logic             uf;

            always_comb begin
                inc = issue && (id_rd_addr == 5'(gi));
                dec = {1'b0, wb_valid && (wb_rd_addr == 5'(gi))}
                    + {1'b0, cancel_valid && (cancel_rd_addr == 5'(gi))};
                sum = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, inc};
                uf  = (sum < (CNT_W+1)'(dec));
                cnt_next = uf ? '0 : (sum - (CNT_W+1)'(dec));
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next[CNT_W-1:0];
                end
            end

            assign cnt_flat[gi]  = cnt_reg;
            assign underflow[gi] = uf;
            assign pending[gi]   = |cnt_reg;
        end
    endgenerate

    assign cnt_ra = cnt_flat[id_ra_addr];
    assign cnt_rb = cnt_flat[id_rb_addr];
    assign cnt_rd = cnt_flat[id_rd_addr];

    // With bypass enabled, the last outstanding write to a source retires this
    // cycle, so the operand can be picked up from the writeback path.
    assign byp_a = (WB_BYPASS != 0) && wb_valid && (wb_rd_addr == id_ra_addr) && (cnt_ra == CNT_ONE);
    assign byp_b = (WB_BYPASS != 0) && wb_valid && (wb_rd_addr == id_rb_addr) && (cnt_rb == CNT_ONE);

    assign haz_a = id_uses_ra && (id_ra_addr != 5'd0) && (cnt_ra != '0) && !byp_a;
    assign haz_b = id_uses_rb && (id_rb_addr != 5'd0) && (cnt_rb != '0) && !byp_b;
    assign haz_d = (id_rd_addr != 5'd0) && (cnt_rd == CNT_MAX);

    assign id_stall = id_valid && !flush && (haz_a || haz_b || haz_d);
    assign issue    = id_valid && !flush && !id_stall && ex_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_err_reg       <= 1'b0;
            stall_cycles_reg <= '0;
        end else begin
            sb_err_reg <= sb_err_reg || (|underflow);
            if (id_stall && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    assign busy         = |pending;
    assign sb_err       = sb_err_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_id_interlock.sv
// Directed bench for id_interlock: one instance without and one with writeback bypass,
// both driven from the same stimulus.
module tb_id_interlock;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_ra, id_uses_rb;
    logic [4:0]  id_ra_addr, id_rb_addr, id_rd_addr;
    logic        ex_ready, flush;
    logic        cancel_valid;
    logic [4:0]  cancel_rd_addr;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;

    logic        id_stall0, issue0, busy0, sb_err0;
    logic [31:0] pending0, stall_cycles0;
    logic        id_stall1, issue1, busy1, sb_err1;
    logic [31:0] pending1, stall_cycles1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    id_interlock #(.CNT_W(2), .WB_BYPASS(0)) dut0 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr), .id_rd_addr(id_rd_addr),
        .ex_ready(ex_ready), .flush(flush),
        .cancel_valid(cancel_valid), .cancel_rd_addr(cancel_rd_addr),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .id_stall(id_stall0), .issue(issue0), .pending(pending0), .busy(busy0),
        .sb_err(sb_err0), .stall_cycles(stall_cycles0)
    );

    id_interlock #(.CNT_W(2), .WB_BYPASS(1)) dut1 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr), .id_rd_addr(id_rd_addr),
        .ex_ready(ex_ready), .flush(flush),
        .cancel_valid(cancel_valid), .cancel_rd_addr(cancel_rd_addr),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .id_stall(id_stall1), .issue(issue1), .pending(pending1), .busy(busy1),
        .sb_err(sb_err1), .stall_cycles(stall_cycles1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_uses_ra = 0; id_uses_rb = 0;
        id_ra_addr = 0; id_rb_addr = 0; id_rd_addr = 0;
        flush = 0; cancel_valid = 0; cancel_rd_addr = 0;
        wb_valid = 0; wb_rd_addr = 0;
    endtask

    initial begin
        rst = 1; idle(); ex_ready = 1;
        tick(); tick();
        chk("reset_pending", pending0, 32'h0);
        chk("reset_busy", {31'd0, busy0}, 32'd0);
        chk("reset_sb_err", {31'd0, sb_err0}, 32'd0);
        chk("reset_stall_cycles", stall_cycles0, 32'd0);
        chk("reset_id_stall", {31'd0, id_stall0}, 32'd0);
        chk("reset_issue", {31'd0, issue0}, 32'd0);
        rst = 0; settle();

        // RAW on r5
        id_valid = 1; id_rd_addr = 5; settle();
        chk("raw_producer_issue", {31'd0, issue0}, 32'd1);
        tick();
        chk("raw_pending_r5", pending0, 32'h0000_0020);
        chk("raw_busy", {31'd0, busy0}, 32'd1);
        id_rd_addr = 0; id_uses_ra = 1; id_ra_addr = 5; settle();
        chk("raw_stall", {31'd0, id_stall0}, 32'd1);
        chk("raw_no_issue", {31'd0, issue0}, 32'd0);
        tick(); tick();
        wb_valid = 1; wb_rd_addr = 5; settle();
        chk("raw_wb_cycle_stall_nobyp", {31'd0, id_stall0}, 32'd1);
        chk("raw_wb_cycle_issue_nobyp", {31'd0, issue0}, 32'd0);
        chk("raw_wb_cycle_issue_byp", {31'd0, issue1}, 32'd1);
        chk("raw_wb_cycle_stall_byp", {31'd0, id_stall1}, 32'd0);
        tick();
        wb_valid = 0; settle();
        chk("raw_release_pending", pending0, 32'h0);
        chk("raw_release_stall", {31'd0, id_stall0}, 32'd0);
        chk("raw_release_issue", {31'd0, issue0}, 32'd1);
        chk("raw_stall_cycles_nobyp", stall_cycles0, 32'd3);
        chk("raw_stall_cycles_byp", stall_cycles1, 32'd2);
        tick();
        chk("rd0_issue_pending", pending0, 32'h0);

        id_uses_ra = 0; ex_ready = 0; settle();
        chk("backpressure_issue", {31'd0, issue0}, 32'd0);
        chk("backpressure_stall", {31'd0, id_stall0}, 32'd0);
        ex_ready = 1;

        // WAW saturation on r7
        id_rd_addr = 7; settle();
        chk("sat_issue1", {31'd0, issue0}, 32'd1);
        tick(); tick(); tick();
        chk("sat_pending_r7", pending0, 32'h0000_0080);
        chk("sat_haz_d_stall", {31'd0, id_stall0}, 32'd1);
        chk("sat_haz_d_issue", {31'd0, issue0}, 32'd0);
        wb_valid = 1; wb_rd_addr = 7; settle();
        chk("sat_wb_cycle_stall", {31'd0, id_stall0}, 32'd1);
        tick();
        wb_valid = 0; settle();
        chk("sat_after_wb_stall", {31'd0, id_stall0}, 32'd0);
        chk("sat_after_wb_issue", {31'd0, issue0}, 32'd1);
        tick();
        id_valid = 0; settle();
        chk("sat_pending_kept", pending0, 32'h0000_0080);
        chk("sat_stall_cycles", stall_cycles0, 32'd4);
        wb_valid = 1; wb_rd_addr = 7;
        tick(); tick(); tick();
        wb_valid = 0; settle();
        chk("sat_drained", pending0, 32'h0);
        chk("sat_no_err", {31'd0, sb_err0}, 32'd0);

        // Simultaneous issue/wb/cancel on r3
        id_valid = 1; id_rd_addr = 3;
        tick();
        wb_valid = 1; wb_rd_addr = 3; settle();
        chk("sim_issue_with_wb", {31'd0, issue0}, 32'd1);
        tick();
        chk("sim_issue_wb_net0", pending0, 32'h0000_0008);
        cancel_valid = 1; cancel_rd_addr = 3;
        tick();
        idle(); settle();
        chk("sim_issue_wb_cancel_net_m1", pending0, 32'h0);
        chk("sim_no_err", {31'd0, sb_err0}, 32'd0);

        // r0 handling and underflow error
        id_valid = 1; id_uses_ra = 1; id_ra_addr = 0; id_rd_addr = 0; settle();
        chk("ra0_no_stall", {31'd0, id_stall0}, 32'd0);
        chk("ra0_issue", {31'd0, issue0}, 32'd1);
        tick();
        idle(); wb_valid = 1; wb_rd_addr = 0;
        tick();
        chk("wb_r0_no_err", {31'd0, sb_err0}, 32'd0);
        wb_rd_addr = 9;
        tick();
        chk("wb_r9_underflow_err", {31'd0, sb_err0}, 32'd1);
        wb_valid = 0;
        tick();
        chk("sb_err_sticky", {31'd0, sb_err0}, 32'd1);
        chk("underflow_pending_zero", pending0, 32'h0);

        // Flush priority, then asynchronous reset mid-stream
        id_valid = 1; id_rd_addr = 5;
        tick();
        id_rd_addr = 0; id_uses_ra = 1; id_ra_addr = 5; flush = 1; settle();
        chk("flush_stall", {31'd0, id_stall0}, 32'd0);
        chk("flush_issue", {31'd0, issue0}, 32'd0);
        tick();
        flush = 0; id_uses_ra = 0; id_rd_addr = 8; settle();
        chk("post_flush_issue", {31'd0, issue0}, 32'd1);
        tick();
        idle(); settle();
        chk("pre_rst_pending", pending0, 32'h0000_0120);
        chk("pre_rst_stall_cycles", stall_cycles0, 32'd4);
        rst = 1; settle();
        chk("async_rst_pending", pending0, 32'h0);
        chk("async_rst_busy", {31'd0, busy0}, 32'd0);
        chk("async_rst_stall_cycles", stall_cycles0, 32'd0);
        chk("async_rst_sb_err", {31'd0, sb_err0}, 32'd0);
        rst = 0;
        tick();
        chk("post_rst_pending", pending0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
